// File: rtl/spart_core.sv
// Bus-side SPART: register interface, programmable baud generator, 8N1 transmitter and receiver.
// The baud generator runs at OVERSAMPLE ticks per bit; RX samples mid-bit off a synchronized rxd.
module spart_core #(
  parameter logic [15:0] DIV_RESET  = 16'd162,
  parameter int          OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0] div_reg, baud_cnt_reg;
  logic        tick;

  state_t      tx_state_reg;
  logic [7:0]  tx_shift_reg;
  logic [2:0]  tx_idx_reg;
  logic [3:0]  tx_tcnt_reg;
  logic        tx_run_reg, txd_reg, tbr_reg;

  state_t      rx_state_reg;
  logic        rx_meta_reg, rxs_reg, rx_armed_reg;
  logic [7:0]  rx_shift_reg, rx_buf_reg;
  logic [2:0]  rx_idx_reg;
  logic [3:0]  rx_tcnt_reg;
  logic        rda_reg, fe_reg, oe_reg;

  logic        bus_wr, bus_rd, wr_tx, rd_buf, rd_stat;
  logic [7:0]  rd_data;

  assign bus_wr  = iocs && !iorw;
  assign bus_rd  = iocs && iorw;
  assign wr_tx   = bus_wr && (ioaddr == 2'b00) && tbr_reg;
  assign rd_buf  = bus_rd && (ioaddr == 2'b00);
  assign rd_stat = bus_rd && (ioaddr == 2'b01);

  assign rd_data = ioaddr[0] ? {4'b0000, oe_reg, fe_reg, tbr_reg, rda_reg} : rx_buf_reg;
  assign databus = (bus_rd && !ioaddr[1]) ? rd_data : 8'hzz;

  assign tick = (baud_cnt_reg == 16'd0);
  assign rda  = rda_reg;
  assign tbr  = tbr_reg;
  assign txd  = txd_reg;

  // Divisor writes reload the counter so a new rate starts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg      <= DIV_RESET;
      baud_cnt_reg <= DIV_RESET;
    end else if (bus_wr && ioaddr == 2'b10) begin
      div_reg[7:0] <= databus;
      baud_cnt_reg <= {div_reg[15:8], databus};
    end else if (bus_wr && ioaddr == 2'b11) begin
      div_reg[15:8] <= databus;
      baud_cnt_reg  <= {databus, div_reg[7:0]};
    end else if (tick) begin
      baud_cnt_reg <= div_reg;
    end else begin
      baud_cnt_reg <= baud_cnt_reg - 16'd1;
    end
  end

  // START holds txd high until the first tick so every bit spans exactly OVERSAMPLE ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= IDLE;
      tx_shift_reg <= 8'h00;
      tx_idx_reg   <= 3'd0;
      tx_tcnt_reg  <= 4'd0;
      tx_run_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      tbr_reg      <= 1'b1;
    end else begin
      case (tx_state_reg)
        IDLE: if (wr_tx) begin
          tx_shift_reg <= databus;
          tbr_reg      <= 1'b0;
          tx_run_reg   <= 1'b0;
          tx_state_reg <= START;
        end
        START: if (tick) begin
          if (!tx_run_reg) begin
            tx_run_reg  <= 1'b1;
            txd_reg     <= 1'b0;
            tx_tcnt_reg <= 4'd0;
          end else begin
            tx_tcnt_reg <= tx_tcnt_reg + 4'd1;
            if (tx_tcnt_reg == LAST_TICK) begin
              txd_reg      <= tx_shift_reg[0];
              tx_idx_reg   <= 3'd0;
              tx_state_reg <= DATA;
            end
          end
        end
        DATA: if (tick) begin
          tx_tcnt_reg <= tx_tcnt_reg + 4'd1;
          if (tx_tcnt_reg == LAST_TICK) begin
            tx_idx_reg <= tx_idx_reg + 3'd1;
            if (tx_idx_reg == 3'd7) begin
              txd_reg      <= 1'b1;
              tx_state_reg <= STOP;
            end else begin
              txd_reg      <= tx_shift_reg[1];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            end
          end
        end
        STOP: if (tick) begin
          tx_tcnt_reg <= tx_tcnt_reg + 4'd1;
          if (tx_tcnt_reg == LAST_TICK) begin
            tbr_reg      <= 1'b1;
            tx_state_reg <= IDLE;
          end
        end
        default: tx_state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= rxd;
      rxs_reg     <= rx_meta_reg;
    end
  end

  // Bus clears come first so that RX events in the same cycle override them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= IDLE;
      rx_armed_reg <= 1'b0;
      rx_shift_reg <= 8'h00;
      rx_buf_reg   <= 8'h00;
      rx_idx_reg   <= 3'd0;
      rx_tcnt_reg  <= 4'd0;
      rda_reg      <= 1'b0;
      fe_reg       <= 1'b0;
      oe_reg       <= 1'b0;
    end else begin
      if (rd_buf) begin
        rda_reg <= 1'b0;
        oe_reg  <= 1'b0;
      end
      if (rd_stat) fe_reg <= 1'b0;
      case (rx_state_reg)
        IDLE: begin
          if (rxs_reg) rx_armed_reg <= 1'b1;
          if (tick && !rxs_reg && rx_armed_reg) begin
            rx_armed_reg <= 1'b0;
            rx_tcnt_reg  <= 4'd0;
            rx_state_reg <= START;
          end
        end
        START: if (tick) begin
          rx_tcnt_reg <= rx_tcnt_reg + 4'd1;
          if (rx_tcnt_reg == MID_TICK) begin
            rx_tcnt_reg  <= 4'd0;
            rx_idx_reg   <= 3'd0;
            rx_state_reg <= rxs_reg ? IDLE : DATA;
          end
        end
        DATA: if (tick) begin
          rx_tcnt_reg <= rx_tcnt_reg + 4'd1;
          if (rx_tcnt_reg == LAST_TICK) begin
            rx_shift_reg <= {rxs_reg, rx_shift_reg[7:1]};
            rx_idx_reg   <= rx_idx_reg + 3'd1;
            if (rx_idx_reg == 3'd7) rx_state_reg <= STOP;
          end
        end
        STOP: if (tick) begin
          rx_tcnt_reg <= rx_tcnt_reg + 4'd1;
          if (rx_tcnt_reg == LAST_TICK) begin
            if (rxs_reg) begin
              rx_buf_reg <= rx_shift_reg;
              oe_reg     <= rda_reg && !rd_buf;
              rda_reg    <= 1'b1;
            end else begin
              fe_reg <= 1'b1;
            end
            rx_state_reg <= IDLE;
          end
        end
        default: rx_state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_core.sv
// Directed bench for spart_core: bus reads are scored by a monitor against a queue of
// expected values, and a txd monitor decodes transmitted frames against a second queue.
`timescale 1ns/1ps
module tb_spart_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] dbus_drv = 8'h00;
  logic       dbus_oe = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop = 1'b0;
  wire  [7:0] databus;
  logic       rda, tbr, txd;
  logic       rxd;

  int n_tests = 0;
  int n_fail  = 0;
  int bit_clks = 2608;
  logic tx_mon_en = 1'b0;
  int tx_frames = 0;

  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];

  assign databus = dbus_oe ? dbus_drv : 8'hzz;
  assign rxd = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  spart_core dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", nm, act);
    end
  endfunction

  // Read monitor: every bus read cycle consumes one expected value.
  always @(negedge clk) begin
    if (iocs && iorw) begin
      if (rd_exp_q.size() == 0) begin
        chk("unexpected bus read", 1, 0);
      end else begin
        chk(rd_name_q.pop_front(), int'(databus), int'(rd_exp_q.pop_front()));
      end
    end
  end

  // TX monitor: decode 8N1 frames at mid-bit using the current bit period.
  initial begin
    logic [7:0] b;
    logic       s;
    forever begin
      @(negedge clk);
      if (tx_mon_en && txd == 1'b0) begin
        repeat (bit_clks + bit_clks / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = txd;
          if (i < 7) repeat (bit_clks) @(negedge clk);
        end
        repeat (bit_clks) @(negedge clk);
        s = txd;
        if (tx_exp_q.size() == 0) chk("unexpected tx frame", 1, 0);
        else chk("tx frame byte", int'(b), int'(tx_exp_q.pop_front()));
        chk("tx stop bit", int'(s), 1);
        tx_frames++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cyc(1);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; dbus_drv = d; dbus_oe = 1'b1;
    cyc(1);
    iocs = 1'b0; dbus_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    cyc(1);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    cyc(1);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0; cyc(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i]; cyc(bit_clks);
    end
    rxd_drv = stop; cyc(bit_clks);
    rxd_drv = 1'b1; cyc(bit_clks);
  endtask

  // Wait for txd to reach lvl, then count clocks until it leaves that level.
  task automatic measure(input logic lvl, input int exp, input string nm);
    int w = 0;
    int n = 0;
    while (txd !== lvl && w < 2000) begin @(negedge clk); w++; end
    while (txd === lvl && n < 25000) begin @(negedge clk); n++; end
    chk(nm, n, exp);
  endtask

  task automatic check_now(input string nm, input logic act, input logic exp);
    @(negedge clk);
    chk(nm, int'(act), int'(exp));
  endtask

  initial begin
    int w;
    cyc(4);
    rst = 1'b0;

    // Reset state
    check_now("reset txd", txd, 1'b1);
    check_now("reset tbr", tbr, 1'b1);
    check_now("reset rda", rda, 1'b0);
    bus_read(2'b01, 8'h02, "reset status");

    // 1: 0x55 at the reset divisor
    bit_clks = 163 * 16;
    tx_mon_en = 1'b1;
    tx_exp_q.push_back(8'h55);
    bus_write(2'b00, 8'h55);
    check_now("t1 tbr low after write", tbr, 1'b0);
    measure(1'b0, 2608, "t1 start bit clocks");
    measure(1'b1, 2608, "t1 bit0 clocks");
    check_now("t1 tbr low mid frame", tbr, 1'b0);
    w = 0;
    while (tx_frames < 1 && w < 30000) begin cyc(1); w++; end
    chk("t1 frame done in time", int'(tx_frames >= 1), 1);
    cyc(1400);
    check_now("t1 tbr high after stop", tbr, 1'b1);
    check_now("t1 txd idle", txd, 1'b1);

    // 2: loopback at divisor 15 (256 clocks per bit)
    bus_write(2'b10, 8'h0F);
    bit_clks = 256;
    loop = 1'b1;
    tx_exp_q.push_back(8'hA5);
    bus_write(2'b00, 8'hA5);
    w = 0;
    while (rda !== 1'b1 && w < 4000) begin cyc(1); w++; end
    check_now("t2 rda after stop", rda, 1'b1);
    w = 0;
    while (tbr !== 1'b1 && w < 2000) begin cyc(1); w++; end
    check_now("t2 tbr back", tbr, 1'b1);
    bus_read(2'b00, 8'hA5, "t2 rx byte");
    check_now("t2 rda cleared", rda, 1'b0);
    bus_read(2'b01, 8'h02, "t2 status");
    loop = 1'b0;
    w = 0;
    while (tx_frames < 2 && w < 4000) begin cyc(1); w++; end
    tx_mon_en = 1'b0;

    // 4: framing error then status clear
    send_rx(8'h81, 1'b0);
    check_now("t4 rda stays low", rda, 1'b0);
    bus_read(2'b01, 8'h06, "t4 status fe");
    bus_read(2'b01, 8'h02, "t4 status cleared");

    // 5: overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(2'b01, 8'h0B, "t5 status oe");
    bus_read(2'b00, 8'h22, "t5 rx byte");
    bus_read(2'b01, 8'h02, "t5 status cleared");

    // 6a: short glitch is a false start
    rxd_drv = 1'b0; cyc(64);
    rxd_drv = 1'b1; cyc(600);
    check_now("t6 glitch rda", rda, 1'b0);
    bus_read(2'b01, 8'h02, "t6 glitch status");

    // 3: divisor 0x0510, second write while busy is dropped
    bus_write(2'b10, 8'h10);
    bus_write(2'b11, 8'h05);
    bus_write(2'b00, 8'hC3);
    check_now("t3 tbr low", tbr, 1'b0);
    bus_write(2'b00, 8'h3C);
    measure(1'b0, 1297 * 16, "t3 start bit clocks");
    check_now("t3 tbr still low", tbr, 1'b0);

    // 6b: reset mid-frame restores the default divisor
    cyc(1);
    rst = 1'b1;
    @(posedge clk);
    check_now("t6 txd after rst", txd, 1'b1);
    chk("t6 tbr after rst", int'(tbr), 1);
    #1 rst = 1'b0;
    bus_write(2'b00, 8'h01);
    measure(1'b0, 2608, "t6 reset divisor start bit");

    cyc(2);
    chk("read queue drained", rd_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
